// File: rtl/ghost_mode_scheduler.sv
// ghost_mode_scheduler
//
// Runs the scatter/chase schedule for one Pac-Man level. The system clock
// is divided into one-second ticks. Each tick walks a fixed table of
// alternating scatter/chase phases. Phase 7 is chase forever.
//
// Eating an energizer overlays a frightened period. The phase timer is
// saved and frozen for that period, then restored when frightened ends.
//
// Ports:
//   Clk        system clock
//   Reset      asynchronous, active-low reset (0 = reset)
//   start      one-cycle pulse, begins or restarts the level schedule
//   pause      level, freezes all timing and drops energizer pulses
//   energizer  one-cycle pulse, energizer eaten
//   mode       0 IDLE, 1 SCATTER, 2 CHASE, 3 FRIGHT
//   phase      current schedule phase 0..7
//   secs_left  seconds remaining in the current phase or frightened period
//   flashing   high in FRIGHT once secs_left <= FLASH_SEC
//   reverse    one-cycle pulse, ghosts must reverse direction
//   sec_tick   one-cycle pulse per elapsed unpaused second
module ghost_mode_scheduler #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int SCATTER0   = 7,
    parameter int CHASE0     = 20,
    parameter int SCATTER1   = 7,
    parameter int CHASE1     = 20,
    parameter int SCATTER2   = 5,
    parameter int CHASE2     = 20,
    parameter int SCATTER3   = 5,
    parameter int FRIGHT_SEC = 6,
    parameter int FLASH_SEC  = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       pause,
    input  logic       energizer,
    output logic [1:0] mode,
    output logic [2:0] phase,
    output logic [7:0] secs_left,
    output logic       flashing,
    output logic       reverse,
    output logic       sec_tick
);

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESCALE_MAX = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        MODE_IDLE    = 2'd0,
        MODE_SCATTER = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_FRIGHT  = 2'd3
    } mode_t;

    mode_t          mode_q, mode_d;
    mode_t          saved_mode_q, saved_mode_d;
    logic [2:0]     phase_q, phase_d;
    logic [7:0]     secs_q, secs_d;
    logic [7:0]     saved_secs_q, saved_secs_d;
    logic [PW-1:0]  prescaler_q, prescaler_d;
    logic           flashing_q, flashing_d;
    logic           reverse_q, reverse_d;
    logic           sec_tick_q, sec_tick_d;

    logic           running;
    logic           tick;
    logic           accept_energizer;
    logic           phase_end;

    // Duration of each schedule phase. Phase 7 has no end, so it reports 0.
    function automatic logic [7:0] phase_duration(input logic [2:0] p);
        logic [7:0] d;
        case (p)
            3'd0:    d = 8'(SCATTER0);
            3'd1:    d = 8'(CHASE0);
            3'd2:    d = 8'(SCATTER1);
            3'd3:    d = 8'(CHASE1);
            3'd4:    d = 8'(SCATTER2);
            3'd5:    d = 8'(CHASE2);
            3'd6:    d = 8'(SCATTER3);
            default: d = 8'd0;
        endcase
        return d;
    endfunction

    // The prescaler only runs while a level is active and unpaused.
    // A start reloads the prescaler, so any tick in that same cycle is
    // swallowed and the first second is counted from the restart.
    // An energizer is only taken while the timing is live.
    // A phase ends on a tick that finds the last second of a timed
    // scatter/chase phase.
    assign running          = (mode_q != MODE_IDLE) && !pause;
    assign tick             = running && (prescaler_q == '0) && !start;
    assign accept_energizer = running && energizer && !start;
    assign phase_end        = tick && !accept_energizer
                              && (mode_q == MODE_SCATTER || mode_q == MODE_CHASE)
                              && (phase_q != 3'd7) && (secs_q == 8'd1);

    // State register: all schedule state and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mode_q       <= MODE_IDLE;
            saved_mode_q <= MODE_IDLE;
            phase_q      <= 3'd0;
            secs_q       <= 8'd0;
            saved_secs_q <= 8'd0;
            prescaler_q  <= '0;
            flashing_q   <= 1'b0;
            reverse_q    <= 1'b0;
            sec_tick_q   <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            saved_mode_q <= saved_mode_d;
            phase_q      <= phase_d;
            secs_q       <= secs_d;
            saved_secs_q <= saved_secs_d;
            prescaler_q  <= prescaler_d;
            flashing_q   <= flashing_d;
            reverse_q    <= reverse_d;
            sec_tick_q   <= sec_tick_d;
        end
    end

    // Next-state logic. Priority is start, then energizer, then tick.
    // An energizer that lands on a tick throws the tick away. The prescaler
    // still reloads, so the second boundary stays where it was.
    always_comb begin
        mode_d       = mode_q;
        saved_mode_d = saved_mode_q;
        phase_d      = phase_q;
        secs_d       = secs_q;
        saved_secs_d = saved_secs_q;
        prescaler_d  = prescaler_q;

        if (start) begin
            mode_d       = MODE_SCATTER;
            phase_d      = 3'd0;
            secs_d       = phase_duration(3'd0);
            prescaler_d  = PRESCALE_MAX;
            saved_mode_d = MODE_IDLE;
            saved_secs_d = 8'd0;
        end else begin
            if (running) begin
                prescaler_d = (prescaler_q == '0) ? PRESCALE_MAX : prescaler_q - 1'b1;
            end

            if (accept_energizer) begin
                // Save the schedule only on the first energizer. A re-eat
                // must not overwrite the saved schedule with FRIGHT.
                if (mode_q != MODE_FRIGHT) begin
                    saved_mode_d = mode_q;
                    saved_secs_d = secs_q;
                end
                mode_d = MODE_FRIGHT;
                secs_d = 8'(FRIGHT_SEC);
            end else if (tick) begin
                if (mode_q == MODE_FRIGHT) begin
                    if (secs_q > 8'd1) begin
                        secs_d = secs_q - 8'd1;
                    end else begin
                        mode_d = saved_mode_q;
                        secs_d = saved_secs_q;
                    end
                end else if (phase_q == 3'd7) begin
                    mode_d = MODE_CHASE;
                end else if (secs_q > 8'd1) begin
                    secs_d = secs_q - 8'd1;
                end else begin
                    phase_d = phase_q + 3'd1;
                    secs_d  = phase_duration(phase_q + 3'd1);
                    mode_d  = (mode_q == MODE_SCATTER) ? MODE_CHASE : MODE_SCATTER;
                end
            end
        end
    end

    // Output logic. These values are computed ahead of the register, so
    // they change on the same edge as the event that causes them.
    always_comb begin
        flashing_d = (mode_d == MODE_FRIGHT) && (secs_d <= 8'(FLASH_SEC));
        reverse_d  = accept_energizer || phase_end;
        sec_tick_d = tick;
    end

    assign mode      = mode_q;
    assign phase     = phase_q;
    assign secs_left = secs_q;
    assign flashing  = flashing_q;
    assign reverse   = reverse_q;
    assign sec_tick  = sec_tick_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// tb_ghost_mode_scheduler
//
// Directed and random stimulus for ghost_mode_scheduler, with a small
// behavioural model of the schedule. The model counts cycles up within
// each second and derives scatter/chase from the parity of the phase.
module tb_ghost_mode_scheduler;

    localparam int CLK_HZ     = 4;
    localparam int SCATTER0   = 2;
    localparam int CHASE0     = 3;
    localparam int SCATTER1   = 2;
    localparam int CHASE1     = 3;
    localparam int SCATTER2   = 2;
    localparam int CHASE2     = 3;
    localparam int SCATTER3   = 2;
    localparam int FRIGHT_SEC = 3;
    localparam int FLASH_SEC  = 1;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       energizer = 1'b0;
    logic [1:0] mode;
    logic [2:0] phase;
    logic [7:0] secs_left;
    logic       flashing;
    logic       reverse;
    logic       sec_tick;

    int total = 0;
    int bad = 0;

    // Model state
    int m_mode, m_phase, m_secs, m_saved_mode, m_saved_secs, m_cnt;
    bit m_flash, m_rev, m_tick;
    int durTable[8] = '{SCATTER0, CHASE0, SCATTER1, CHASE1, SCATTER2, CHASE2, SCATTER3, 0};

    ghost_mode_scheduler #(
        .CLK_HZ(CLK_HZ), .SCATTER0(SCATTER0), .CHASE0(CHASE0),
        .SCATTER1(SCATTER1), .CHASE1(CHASE1), .SCATTER2(SCATTER2),
        .CHASE2(CHASE2), .SCATTER3(SCATTER3),
        .FRIGHT_SEC(FRIGHT_SEC), .FLASH_SEC(FLASH_SEC)
    ) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .pause(pause),
        .energizer(energizer), .mode(mode), .phase(phase),
        .secs_left(secs_left), .flashing(flashing), .reverse(reverse),
        .sec_tick(sec_tick)
    );

    // Free-running clock with a 10 ns period
    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("mode", 32'(mode), m_mode);
        checkVal("phase", 32'(phase), m_phase);
        checkVal("secs_left", 32'(secs_left), m_secs);
        checkVal("flashing", 32'(flashing), 32'(m_flash));
        checkVal("reverse", 32'(reverse), 32'(m_rev));
        checkVal("sec_tick", 32'(sec_tick), 32'(m_tick));
    endtask

    task automatic modelReset();
        m_mode = 0; m_phase = 0; m_secs = 0; m_saved_mode = 0; m_saved_secs = 0;
        m_cnt = 0; m_flash = 0; m_rev = 0; m_tick = 0;
    endtask

    // One clock of the schedule, written from the behavioural rules
    task automatic modelStep(input bit s, input bit p, input bit e);
        bit running;
        bit tick;
        running = (m_mode != 0) && !p;
        tick = 0;
        m_rev = 0;
        m_tick = 0;
        if (s) begin
            m_mode = 1; m_phase = 0; m_secs = durTable[0]; m_cnt = 0;
            m_saved_mode = 0; m_saved_secs = 0;
        end else begin
            if (running) begin
                if (m_cnt == CLK_HZ - 1) begin
                    tick = 1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            m_tick = tick;
            if (e && running) begin
                if (m_mode != 3) begin
                    m_saved_mode = m_mode;
                    m_saved_secs = m_secs;
                end
                m_mode = 3;
                m_secs = FRIGHT_SEC;
                m_rev = 1;
            end else if (tick) begin
                if (m_mode == 3) begin
                    if (m_secs > 1) m_secs--;
                    else begin
                        m_mode = m_saved_mode;
                        m_secs = m_saved_secs;
                    end
                end else if (m_phase == 7) begin
                    m_mode = 2;
                end else if (m_secs > 1) begin
                    m_secs--;
                end else begin
                    m_phase++;
                    m_mode = (m_phase % 2 == 1) ? 2 : 1;
                    m_secs = durTable[m_phase];
                    m_rev = 1;
                end
            end
        end
        m_flash = (m_mode == 3) && (m_secs <= FLASH_SEC);
    endtask

    // Drive one cycle of inputs, advance the model, then check all outputs
    task automatic applyStimulus(input bit s, input bit p, input bit e);
        start = s;
        pause = p;
        energizer = e;
        @(posedge Clk);
        if (Reset) modelStep(s, p, e);
        else modelReset();
        #1;
        start = 1'b0;
        energizer = 1'b0;
        checkOutput();
    endtask

    initial begin
        int frozenSecs;
        bit p;
        modelReset();

        // Reset held, then idle with no start
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);
        Reset = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1);

        // Start and first phase advance
        applyStimulus(1, 0, 0);
        checkVal("start_mode", 32'(mode), 1);
        checkVal("start_secs", 32'(secs_left), 2);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0);
        checkVal("first_tick", 32'(sec_tick), 1);
        checkVal("first_tick_secs", 32'(secs_left), 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0);
        checkVal("adv_mode", 32'(mode), 2);
        checkVal("adv_phase", 32'(phase), 1);
        checkVal("adv_secs", 32'(secs_left), 3);
        checkVal("adv_reverse", 32'(reverse), 1);
        applyStimulus(0, 0, 0);
        checkVal("adv_reverse_drop", 32'(reverse), 0);

        // Fright overlay, then re-energize on the last fright second
        applyStimulus(0, 0, 1);
        checkVal("fright_mode", 32'(mode), 3);
        checkVal("fright_secs", 32'(secs_left), FRIGHT_SEC);
        checkVal("fright_reverse", 32'(reverse), 1);
        for (int i = 0; i < 40 && !(m_mode == 3 && m_secs == 1); i++) applyStimulus(0, 0, 0);
        checkVal("flash_rise", 32'(flashing), 1);
        applyStimulus(0, 0, 1);
        checkVal("reeat_secs", 32'(secs_left), FRIGHT_SEC);
        checkVal("reeat_flash", 32'(flashing), 0);
        checkVal("reeat_reverse", 32'(reverse), 1);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0);
        checkVal("fright_exit_mode", 32'(mode), 2);
        checkVal("fright_exit_phase", 32'(phase), 1);

        // Pause mid-phase with an energizer that must be dropped
        applyStimulus(0, 0, 0);
        frozenSecs = m_secs;
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, (i == 4));
        checkVal("pause_secs", 32'(secs_left), frozenSecs);
        checkVal("pause_mode", 32'(mode), 2);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0);

        // start beats energizer, then run out to phase 7
        applyStimulus(1, 0, 1);
        checkVal("prio_mode", 32'(mode), 1);
        checkVal("prio_phase", 32'(phase), 0);
        for (int i = 0; i < 90; i++) applyStimulus(0, 0, 0);
        checkVal("end_mode", 32'(mode), 2);
        checkVal("end_phase", 32'(phase), 7);
        checkVal("end_secs", 32'(secs_left), 0);

        // Random traffic
        p = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) p = !p;
            applyStimulus($urandom_range(0, 79) == 0, p, $urandom_range(0, 14) == 0);
        end

        // Async reset in the middle of FRIGHT
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);
        #2;
        Reset = 1'b0;
        #1;
        modelReset();
        checkOutput();
        applyStimulus(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
